// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch stage: default widths, halt opcode, FSM states.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 8;
    localparam int unsigned INSTR_W_DEFAULT = 16;
    localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_pc.sv
// Program counter register with clear, load and increment controls.
// Priority: reset, clear, load, increment, hold.
module cpu_fetch_pc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] pc_q;

    // PC update; increment wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= target;
        end else if (incr) begin
            pc_q <= pc_q + PC_ONE;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: LOAD/RUN/HALT FSM feeding a single-entry
// instruction slot with ready/valid handshake, redirect flush and halt detect.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
    parameter logic [3:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    fetch_state_e       state_q, state_d;
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [15:0]        count_q, count_d;

    logic              pc_clear, pc_load, pc_incr;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;

    assign slot_free = !ir_valid_q || ir_ready;

    cpu_fetch_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clear  (pc_clear),
        .load   (pc_load),
        .target (redirect_target),
        .incr   (pc_incr),
        .pc     (pc)
    );

    // Next-state logic; mode=0 is applied last so it overrides every other event.
    always_comb begin
        state_d    = state_q;
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        count_d    = count_q;
        pc_clear   = 1'b0;
        pc_load    = 1'b0;
        pc_incr    = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (mode) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    // Flush the slot; fetch resumes from the target next cycle.
                    pc_load    = 1'b1;
                    ir_valid_d = 1'b0;
                end else if (slot_free) begin
                    ir_data_d  = instr_in;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_incr    = 1'b1;
                    count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (instr_in[INSTR_W-1 -: 4] == HALT_OP) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase

        if (!mode) begin
            state_d    = StLoad;
            ir_valid_d = 1'b0;
            count_d    = '0;
            pc_clear   = 1'b1;
            pc_load    = 1'b0;
            pc_incr    = 1'b0;
        end
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoad;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            count_q    <= count_d;
        end
    end

    assign pc_out      = pc;
    assign ir_valid    = ir_valid_q;
    assign ir_data     = ir_data_q;
    assign ir_pc       = ir_pc_q;
    assign halted      = (state_q == StHalt);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed self-checking bench for cpu_fetch with a behavioural program RAM.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [15:0] instr_in;
    logic [7:0]  pc_out;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [7:0]  ir_pc;
    logic        ir_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] ram [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign instr_in = ram[pc_out];

    cpu_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .instr_in        (instr_in),
        .pc_out          (pc_out),
        .ir_valid        (ir_valid),
        .ir_data         (ir_data),
        .ir_pc           (ir_pc),
        .ir_ready        (ir_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[0]    = 16'h1111;
        ram[1]    = 16'h2222;
        ram[2]    = 16'h3333;
        ram[3]    = 16'h4444;
        ram[5]    = 16'hF000;
        ram[8'h40] = 16'h0A40;
        ram[8'hFF] = 16'h0001;

        reset = 1'b1; mode = 1'b0; ir_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00;
        tick(); tick();
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_valid", 32'(ir_valid), 32'h0);
        check("rst_data", 32'(ir_data), 32'h0);
        check("rst_irpc", 32'(ir_pc), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);

        // Enter run: first edge moves to RUN, second issues RAM[0].
        reset = 1'b0; mode = 1'b1; ir_ready = 1'b1;
        tick();
        check("run_n1_valid", 32'(ir_valid), 32'h0);
        tick();
        check("f0_valid", 32'(ir_valid), 32'h1);
        check("f0_data", 32'(ir_data), 32'h1111);
        check("f0_irpc", 32'(ir_pc), 32'h0);
        tick();
        check("f1_data", 32'(ir_data), 32'h2222);
        check("f1_irpc", 32'(ir_pc), 32'h1);

        // Stall three cycles holding 2222.
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(ir_valid), 32'h1);
            check("stall_data", 32'(ir_data), 32'h2222);
            check("stall_irpc", 32'(ir_pc), 32'h1);
            check("stall_pc", 32'(pc_out), 32'h2);
        end
        ir_ready = 1'b1;
        tick();
        check("f2_data", 32'(ir_data), 32'h3333);
        check("f2_irpc", 32'(ir_pc), 32'h2);
        tick();
        check("f3_data", 32'(ir_data), 32'h4444);
        check("f3_irpc", 32'(ir_pc), 32'h3);
        check("f3_count", 32'(fetch_count), 32'd4);

        // Redirect wins over ready.
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick();
        check("redir_valid", 32'(ir_valid), 32'h0);
        check("redir_pc", 32'(pc_out), 32'h40);
        check("redir_count", 32'(fetch_count), 32'd4);
        redirect_valid = 1'b0;
        tick();
        check("redir_irpc", 32'(ir_pc), 32'h40);
        check("redir_data", 32'(ir_data), 32'h0A40);
        check("redir_count2", 32'(fetch_count), 32'd5);

        // PC wrap from FF to 00.
        redirect_valid = 1'b1; redirect_target = 8'hFF;
        tick();
        check("wrap_pre_pc", 32'(pc_out), 32'hFF);
        redirect_valid = 1'b0;
        tick();
        check("wrap_irpc", 32'(ir_pc), 32'hFF);
        check("wrap_data", 32'(ir_data), 32'h0001);
        check("wrap_pc", 32'(pc_out), 32'h00);
        check("wrap_count", 32'(fetch_count), 32'd6);
        tick();
        check("post_wrap_data", 32'(ir_data), 32'h1111);
        check("post_wrap_count", 32'(fetch_count), 32'd7);

        // Halt opcode at address 5.
        redirect_valid = 1'b1; redirect_target = 8'h05;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("halt_data", 32'(ir_data), 32'hF000);
        check("halt_irpc", 32'(ir_pc), 32'h5);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc_out), 32'h6);
        check("halt_count", 32'(fetch_count), 32'd8);
        ir_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h20;
        tick();
        check("halt_hold_valid", 32'(ir_valid), 32'h1);
        check("halt_redir_pc", 32'(pc_out), 32'h6);
        ir_ready = 1'b1; redirect_valid = 1'b0;
        tick();
        check("halt_drain_valid", 32'(ir_valid), 32'h0);
        check("halt_drain_count", 32'(fetch_count), 32'd8);
        redirect_valid = 1'b1;
        tick();
        check("halt_redir2_pc", 32'(pc_out), 32'h6);
        check("halt_still", 32'(halted), 32'h1);
        redirect_valid = 1'b0; mode = 1'b0;
        tick();
        check("unhalt_pc", 32'(pc_out), 32'h0);
        check("unhalt_flag", 32'(halted), 32'h0);
        check("unhalt_count", 32'(fetch_count), 32'h0);

        // Drop mode mid-stall.
        mode = 1'b1;
        tick(); tick();
        check("rerun_data", 32'(ir_data), 32'h1111);
        check("rerun_count", 32'(fetch_count), 32'd1);
        ir_ready = 1'b0;
        tick();
        check("rerun_stall_pc", 32'(pc_out), 32'h1);
        mode = 1'b0;
        tick();
        check("drop_valid", 32'(ir_valid), 32'h0);
        check("drop_pc", 32'(pc_out), 32'h0);
        check("drop_count", 32'(fetch_count), 32'h0);

        // Reset overrides a concurrent redirect.
        mode = 1'b1; ir_ready = 1'b1;
        tick(); tick(); tick();
        check("pre_rst_count", 32'(fetch_count), 32'd2);
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h33;
        tick();
        check("rst2_pc", 32'(pc_out), 32'h0);
        check("rst2_valid", 32'(ir_valid), 32'h0);
        check("rst2_data", 32'(ir_data), 32'h0);
        check("rst2_count", 32'(fetch_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter HALT_OP, default 4'hF, opcode (instr[15:12]) that stops fetching.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = load mode (program RAM being written over UART); 1 = run mode.
REQ-007 instr_in  input  INSTR_W  program-RAM read data; combinational function of pc_out, valid in the same cycle.
REQ-008 pc_out  output  ADDR_W  program-RAM read address; equals internal PC register.
REQ-009 ir_valid  output  1  instruction slot holds an instruction for decode.
REQ-010 ir_data  output  INSTR_W  held instruction.
REQ-011 ir_pc  output  ADDR_W  address the held instruction was fetched from.
REQ-012 ir_ready  input  1  decode accepts the slot this cycle when ir_valid=1.
REQ-013 redirect_valid  input  1  branch/jump taken; single-cycle pulse.
REQ-014 redirect_target  input  ADDR_W  new PC on redirect.
REQ-015 halted  output  1  fetch stopped on HALT_OP.
REQ-016 fetch_count  output  16  instructions issued since run start; saturates at 16'hFFFF.

Function
REQ-017 FSM states SHALL be LOAD, RUN, HALT; LOAD on reset.
REQ-018 In LOAD: pc=0, ir_valid=0, fetch_count=0, halted=0; transition to RUN when mode=1 is sampled.
REQ-019 In any state, mode=0 sampled SHALL force LOAD next cycle, clearing ir_valid and pc; this overrides every other event.
REQ-020 Slot free = !ir_valid || ir_ready.
REQ-021 In RUN with slot free and no redirect: ir_data<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 2^ADDR_W (255 wraps to 0), fetch_count increments.
REQ-022 In RUN with ir_valid=1 and ir_ready=0: pc, ir_data, ir_pc, ir_valid SHALL hold (stall).
REQ-023 In RUN, redirect_valid=1 SHALL win over fetch and ready: pc<=redirect_target, ir_valid<=0 (flush), no count increment; fetching resumes next cycle.
REQ-024 Latency: mode sampled high at cycle N -> RUN at N+1 -> ir_valid=1 with ir_pc=0 at N+2; then one instruction per cycle while ir_ready=1.
REQ-025 When a fetch captures instr_in[15:12]==HALT_OP, state SHALL move to HALT with halted=1 in the same update; the HALT instruction is still issued.
REQ-026 In HALT: no fetches, pc holds, redirect_valid ignored; ir_valid clears once the held instruction is accepted (ir_ready=1).
REQ-027 HALT exits only via mode=0 (to LOAD).
REQ-028 fetch_count SHALL stop at 16'hFFFF without wrapping.

Reset
REQ-029 reset=1 SHALL set state=LOAD, pc_out=0, ir_valid=0, ir_data=0, ir_pc=0, halted=0, fetch_count=0, overriding all inputs including mid-stall or mid-redirect.

Structure
REQ-030 ADDR_W, INSTR_W defaults, HALT_OP and FSM state encodings SHALL live in shared package cpu_pkg.
REQ-031 One sub-module, cpu_fetch_pc, SHALL hold the PC register with load/increment/hold controls.

Verification
REQ-032 Reset then mode=1, ir_ready=1, RAM[0..3]=1111,2222,3333,4444 -> ir_data 1111..4444 on consecutive cycles from N+2, ir_pc 0..3, fetch_count=4.
REQ-033 ir_ready=0 for 3 cycles with ir_data=2222 -> ir_data, ir_pc=1, pc_out=2 held; resumes with 3333 after ir_ready=1.
REQ-034 redirect_valid=1, target=8'h40, same cycle ir_ready=1 -> next cycle ir_valid=0, pc_out=8'h40; following cycle ir_pc=8'h40.
REQ-035 PC at 8'hFF, RAM[FF]=0001 -> ir_pc=FF issued, pc_out wraps to 00.
REQ-036 RAM[5]=F000 -> issued with halted=1, pc_out=6 frozen, redirect ignored; mode=0 -> LOAD, pc_out=0, halted=0.
REQ-037 mode dropped mid-stall with ir_valid=1 -> next cycle ir_valid=0, pc_out=0, fetch_count=0.
